// File: rtl/riscv_pipe_pkg.sv
// ============================================================================
// Module : riscv_pipe_pkg
// Brief  : Shared encodings for the RV32I pipeline sequencer (states, PC select, jump codes).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_pipe_pkg;

  // Sequencer state codes
  localparam logic [1:0] ST_INIT     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  // PC source select
  localparam logic [1:0] PC_SEL_PC4 = 2'b00;
  localparam logic [1:0] PC_SEL_JAL = 2'b01;
  localparam logic [1:0] PC_SEL_EX  = 2'b10;

  // Jump code of the instruction in ID
  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_JAL  = 2'b01;
  localparam logic [1:0] JUMP_JALR = 2'b10;

endpackage

`default_nettype wire

// File: rtl/id_hazard_detect.sv
// ============================================================================
// Module : id_hazard_detect
// Brief  : Combinational load-use hazard compare between the EX load and the ID sources.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_hazard_detect (
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  output logic       load_use_o
);

  // x0 is never a real producer, so a load targeting it cannot create a hazard
  always_comb begin
    load_use_o = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                 ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                  (id_use_rs2_i && (id_rs2_i == ex_rd_i)));
  end

endmodule

`default_nettype wire

// File: rtl/id_pipe_ctrl.sv
// ============================================================================
// Module : id_pipe_ctrl
// Brief  : Pipeline sequencer beside ID: PC update, stage enables/flushes, purge and perf counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_pipe_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int INIT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [1:0]       id_jump,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             init_busy,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int                INIT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(INIT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [1:0]        state_q, state_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              load_use;
  logic              freeze;
  logic              stall_inc;
  logic              flush_inc;

  id_hazard_detect u_hazard (
    .ex_mem_read_i (ex_mem_read),
    .ex_rd_i       (ex_rd),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_use_rs1_i  (id_use_rs1),
    .id_use_rs2_i  (id_use_rs2),
    .load_use_o    (load_use)
  );

  assign freeze = mem_req && !dmem_ready;

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    err_d        = err_q;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    pc_write     = 1'b0;
    pc_sel       = PC_SEL_PC4;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b0;
    mem_wb_write = 1'b0;
    init_busy    = 1'b0;

    if (state_q == ST_INIT) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      init_busy   = 1'b1;
      if (init_cnt_q == '0) begin
        state_d = ST_RUN;
      end else begin
        init_cnt_d = init_cnt_q - 1'b1;
      end
    end else if (freeze) begin
      // Whole pipe holds; the wait counter parks at the limit once the error is flagged
      stall_inc = 1'b1;
      state_d   = ST_MEM_WAIT;
      if (wait_cnt_q != WAIT_MAX) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
      if (wait_cnt_d == WAIT_MAX) begin
        err_d = 1'b1;
      end
    end else begin
      state_d      = ST_RUN;
      wait_cnt_d   = '0;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      mem_wb_write = 1'b1;
      if (ex_redirect) begin
        pc_sel      = PC_SEL_EX;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        flush_inc   = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
        stall_inc   = 1'b1;
      end else if (id_jump == JUMP_JAL) begin
        pc_sel      = PC_SEL_JAL;
        if_id_flush = 1'b1;
        flush_inc   = 1'b1;
      end
    end

    stall_cnt_d = (stall_inc && (stall_cnt_q != CNT_MAX)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (flush_inc && (flush_cnt_q != CNT_MAX)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= INIT_LOAD;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_timeout_err = err_q;
  assign stall_cnt       = stall_cnt_q;
  assign flush_cnt       = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_pipe_ctrl.sv
// ============================================================================
// Module : tb_id_pipe_ctrl
// Brief  : Directed self-checking bench for id_pipe_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_pipe_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2;
  logic [1:0] id_jump;
  logic       ex_mem_read, ex_redirect, mem_req, dmem_ready;
  logic       pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic       ex_mem_write, mem_wb_write, init_busy, mem_timeout_err;
  logic [1:0] pc_sel;
  logic [3:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Control bundle: {pc_write, pc_sel, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_write}
  localparam logic [8:0] CTL_INIT   = 9'b0_00_0_1_0_1_0_0;
  localparam logic [8:0] CTL_RUN    = 9'b1_00_1_0_1_0_1_1;
  localparam logic [8:0] CTL_LDUSE  = 9'b0_00_0_0_1_1_1_1;
  localparam logic [8:0] CTL_JAL    = 9'b1_01_1_1_1_0_1_1;
  localparam logic [8:0] CTL_REDIR  = 9'b1_10_1_1_1_1_1_1;
  localparam logic [8:0] CTL_FREEZE = 9'b0_00_0_0_0_0_0_0;

  id_pipe_ctrl #(
    .INIT_CYCLES (4),
    .MEM_TIMEOUT (4),
    .CNT_W       (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_jump         (id_jump),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_redirect     (ex_redirect),
    .mem_req         (mem_req),
    .dmem_ready      (dmem_ready),
    .pc_write        (pc_write),
    .pc_sel          (pc_sel),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_write     (id_ex_write),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_write    (ex_mem_write),
    .mem_wb_write    (mem_wb_write),
    .init_busy       (init_busy),
    .mem_timeout_err (mem_timeout_err),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [8:0] want);
    chk(tag, {23'd0, pc_write, pc_sel, if_id_write, if_id_flush, id_ex_write,
              id_ex_flush, ex_mem_write, mem_wb_write}, {23'd0, want});
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_jump = 2'b00;
    ex_mem_read = 1'b0; ex_redirect = 1'b0; mem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic init_window(input string tag);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({tag, "_busy"}, init_busy, 1);
      chk_ctl({tag, "_ctl"}, CTL_INIT);
    end
    @(negedge clk);
    chk({tag, "_done"}, init_busy, 0);
    chk_ctl({tag, "_run"}, CTL_RUN);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_ctl("rst_ctl", CTL_INIT);
    chk("rst_busy", init_busy, 1);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_flush", flush_cnt, 0);
    chk("rst_err", mem_timeout_err, 0);
    reset = 1'b0;
    init_window("init");

    // Load-use through rs2
    @(negedge clk);
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    #1 chk_ctl("lduse_rs2", CTL_LDUSE);
    @(negedge clk);
    idle();
    #1 chk("lduse_stall", stall_cnt, 1);
    chk_ctl("lduse_release", CTL_RUN);

    // No hazard on x0 or when rs2 is not read
    @(negedge clk);
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b1;
    #1 chk_ctl("lduse_x0", CTL_RUN);
    @(negedge clk);
    ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b0;
    #1 chk_ctl("lduse_nouse", CTL_RUN);

    // Load-use through rs1
    @(negedge clk);
    idle();
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
    #1 chk_ctl("lduse_rs1", CTL_LDUSE);

    // jal from ID, then jalr (no ID redirect)
    @(negedge clk);
    idle();
    id_jump = 2'b01;
    #1 chk("stall_after_rs1", stall_cnt, 2);
    chk_ctl("jal", CTL_JAL);
    @(negedge clk);
    id_jump = 2'b10;
    #1 chk_ctl("jalr_id", CTL_RUN);
    chk("jal_flush", flush_cnt, 1);

    // EX redirect wins over load-use and jal
    @(negedge clk);
    ex_redirect = 1'b1; id_jump = 2'b01;
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    #1 chk_ctl("redir_prio", CTL_REDIR);
    @(negedge clk);
    idle();
    #1 chk("redir_flush", flush_cnt, 2);
    chk("redir_stall", stall_cnt, 2);

    // Freeze three cycles with a pending redirect, then release
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
      #1 chk_ctl("freeze", CTL_FREEZE);
    end
    @(negedge clk);
    dmem_ready = 1'b1;
    #1 chk("freeze_stall", stall_cnt, 5);
    chk("freeze_flush_pre", flush_cnt, 2);
    chk_ctl("freeze_release", CTL_REDIR);
    @(negedge clk);
    idle();
    #1 chk("release_flush", flush_cnt, 3);
    chk("release_err", mem_timeout_err, 0);
    chk_ctl("release_run", CTL_RUN);

    // Timeout: flag sets at the end of the 4th consecutive freeze cycle
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      mem_req = 1'b1; dmem_ready = 1'b0;
      #1 chk("to_err_low", mem_timeout_err, 0);
    end
    @(negedge clk);
    #1 chk("to_err_set", mem_timeout_err, 1);
    chk("to_stall", stall_cnt, 9);
    chk_ctl("to_still_frozen", CTL_FREEZE);
    repeat (8) @(negedge clk);
    #1 chk("stall_sat", stall_cnt, 15);
    @(negedge clk);
    dmem_ready = 1'b1;
    #1 chk_ctl("to_release", CTL_RUN);
    @(negedge clk);
    idle();
    #1 chk("err_sticky", mem_timeout_err, 1);
    chk("stall_sat_hold", stall_cnt, 15);

    // Asynchronous reset in the middle of a freeze
    @(negedge clk);
    mem_req = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("arst_err", mem_timeout_err, 0);
    chk("arst_stall", stall_cnt, 0);
    chk("arst_flush", flush_cnt, 0);
    chk("arst_busy", init_busy, 1);
    chk_ctl("arst_ctl", CTL_INIT);
    idle();
    @(posedge clk);
    #1 reset = 1'b0;
    init_window("reinit");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
